// File: rtl/reg_file_bp.sv
// Two-read/one-write register file with registered reads, optional hardwired
// zero register, optional same-edge write bypass and a post-reset clear sequencer.
module reg_file_bp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            res,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic            RE,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD,
  input  logic            WE,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            READY
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [XLEN-1:0] mem [NREG];

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;

  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // Address names a real register that is not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREG)) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    wr_ok     = (state_q == RUN) && WE && addr_ok(A3);
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = A3;
    mem_wdata = WD;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
      clr_idx_d = clr_idx_q + AW'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // The reset edge leaves the array alone; clearing starts on the next edge.
  always_ff @(posedge clk) begin
    if (!res && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [AW-1:0] rd_addr [2];
  assign rd_addr[0] = A1;
  assign rd_addr[1] = A2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] rd_q, rd_d;

      always_comb begin
        rd_d = rd_q;
        if (state_q == INIT) begin
          rd_d = '0;
        end else if (RE) begin
          if (!addr_ok(rd_addr[gi])) begin
            rd_d = '0;
          end else if (BYPASS && wr_ok && (A3 == rd_addr[gi])) begin
            rd_d = WD;
          end else begin
            rd_d = mem[rd_addr[gi]];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (res) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end
    end
  endgenerate

  assign RD1   = g_rd[0].rd_q;
  assign RD2   = g_rd[1].rd_q;
  assign READY = ready_q;

endmodule

// File: tb/tb_reg_file_bp.sv
// Directed bench: a default build (NREG=32, zero reg, bypass) and an alternate
// build (NREG=24, no zero reg, no bypass) driven by the same stimulus.
module tb_reg_file_bp;

  logic        clk = 1'b0;
  logic        res;
  logic [4:0]  A1, A2, A3;
  logic        RE, WE;
  logic [31:0] WD;

  logic [31:0] rd1_m, rd2_m, rd1_a, rd2_a;
  logic        ready_m, ready_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_bp #(.XLEN(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_m (
    .clk(clk), .res(res), .A1(A1), .A2(A2), .RE(RE), .A3(A3), .WD(WD), .WE(WE),
    .RD1(rd1_m), .RD2(rd2_m), .READY(ready_m)
  );

  reg_file_bp #(.XLEN(32), .NREG(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_a (
    .clk(clk), .res(res), .A1(A1), .A2(A2), .RE(RE), .A3(A3), .WD(WD), .WE(WE),
    .RD1(rd1_a), .RD2(rd2_a), .READY(ready_a)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    res = 1'b1; A1 = '0; A2 = '0; A3 = '0; RE = 1'b1; WE = 1'b0; WD = '0;
    #2;

    // Reset held for 3 edges
    repeat (3) step();
    chk("reset_rd1_m", rd1_m, 32'h0);
    chk("reset_rd2_m", rd2_m, 32'h0);
    chk("reset_ready_m", 32'(ready_m), 32'h0);
    chk("reset_ready_a", 32'(ready_a), 32'h0);
    $display("reset held 3 cycles: ready_m=%0d rd1_m=%h", ready_m, rd1_m);

    // Release, then reset again at clear edge 10
    res = 1'b0;
    repeat (9) step();
    chk("clear9_ready_m", 32'(ready_m), 32'h0);
    res = 1'b1;
    step();
    chk("midclear_reset_ready_m", 32'(ready_m), 32'h0);
    res = 1'b0;
    $display("reset pulsed at clear edge 10");

    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 23) chk("clear23_ready_a", 32'(ready_a), 32'h0);
      if (i == 24) chk("clear24_ready_a", 32'(ready_a), 32'h1);
      if (i == 31) chk("clear31_ready_m", 32'(ready_m), 32'h0);
      if (i == 32) chk("clear32_ready_m", 32'(ready_m), 32'h1);
    end
    $display("clear done: ready_m=%0d ready_a=%0d", ready_m, ready_a);

    // Every register reads zero after the clear
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a); A2 = 5'(31 - a);
      step();
      chk("cleared_rd1_m", rd1_m, 32'h0);
      chk("cleared_rd2_m", rd2_m, 32'h0);
      chk("cleared_rd1_a", rd1_a, 32'h0);
    end
    $display("read all 32 addresses after clear");

    // Write 0xDEADBEEF to reg 5 then read it on both ports
    WE = 1'b1; A3 = 5'd5; WD = 32'hDEADBEEF; A1 = 5'd0; A2 = 5'd1;
    step();
    WE = 1'b0; A1 = 5'd5; A2 = 5'd5;
    step();
    chk("wr5_rd1_m", rd1_m, 32'hDEADBEEF);
    chk("wr5_rd2_m", rd2_m, 32'hDEADBEEF);
    chk("wr5_rd1_a", rd1_a, 32'hDEADBEEF);
    $display("write reg5=deadbeef: rd1_m=%h rd2_m=%h", rd1_m, rd2_m);

    // WE=0 leaves reg 6 untouched
    WE = 1'b0; A3 = 5'd6; WD = 32'h55; A1 = 5'd6; A2 = 5'd6;
    step();
    step();
    chk("nowe_rd1_m", rd1_m, 32'h0);
    chk("nowe_rd1_a", rd1_a, 32'h0);
    $display("we=0 to reg6: rd1_m=%h", rd1_m);

    // Zero register
    WE = 1'b1; A3 = 5'd0; WD = 32'h1234; A1 = 5'd1;
    step();
    WE = 1'b0; A1 = 5'd0;
    step();
    chk("zero_rd1_m", rd1_m, 32'h0);
    chk("zero_rd1_a", rd1_a, 32'h1234);
    $display("write reg0=1234: rd1_m=%h rd1_a=%h", rd1_m, rd1_a);

    // Bypass collision on reg 7
    WE = 1'b1; A3 = 5'd7; WD = 32'h11; A1 = 5'd0;
    step();
    WE = 1'b1; A3 = 5'd7; WD = 32'h22; A1 = 5'd7;
    step();
    chk("bypass_rd1_m", rd1_m, 32'h22);
    chk("bypass_rd1_a", rd1_a, 32'h11);
    WE = 1'b0;
    step();
    chk("after_bypass_rd1_m", rd1_m, 32'h22);
    chk("after_bypass_rd1_a", rd1_a, 32'h22);
    $display("bypass collision reg7: rd1_m=%h rd1_a=%h", rd1_m, rd1_a);

    // Read hold with RE=0
    WE = 1'b1; A3 = 5'd9; WD = 32'hAA; A1 = 5'd0; A2 = 5'd0;
    step();
    WE = 1'b0; A1 = 5'd9; A2 = 5'd9;
    step();
    chk("pre_hold_rd1_m", rd1_m, 32'hAA);
    RE = 1'b0; A1 = 5'd5; A2 = 5'd7;
    step();
    step();
    chk("hold_rd1_m", rd1_m, 32'hAA);
    chk("hold_rd2_m", rd2_m, 32'hAA);
    chk("hold_rd1_a", rd1_a, 32'hAA);
    RE = 1'b1;
    $display("read hold re=0: rd1_m=%h rd2_m=%h", rd1_m, rd2_m);

    // Out-of-range address on the NREG=24 build
    WE = 1'b1; A3 = 5'd30; WD = 32'h77; A1 = 5'd30;
    step();
    chk("oor_coll_rd1_a", rd1_a, 32'h0);
    WE = 1'b0;
    step();
    chk("oor_rd1_a", rd1_a, 32'h0);
    chk("inrange30_rd1_m", rd1_m, 32'h77);
    $display("write addr30=77: rd1_m=%h rd1_a=%h", rd1_m, rd1_a);

    // Fill 1..31 then reset mid-RUN
    WE = 1'b1;
    for (int i = 1; i < 32; i++) begin
      A3 = 5'(i); WD = 32'(i) * 32'h01010101;
      step();
    end
    WE = 1'b0; A1 = 5'd3; A2 = 5'd20;
    step();
    chk("fill_rd1_m", rd1_m, 32'h03030303);
    chk("fill_rd2_a", rd2_a, 32'h14141414);
    res = 1'b1;
    step();
    chk("runreset_rd1_m", rd1_m, 32'h0);
    chk("runreset_rd2_m", rd2_m, 32'h0);
    chk("runreset_ready_m", 32'(ready_m), 32'h0);
    chk("runreset_rd2_a", rd2_a, 32'h0);
    res = 1'b0;
    repeat (32) step();
    chk("reclear_ready_m", 32'(ready_m), 32'h1);
    $display("reset mid-run and re-clear: ready_m=%0d", ready_m);
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a); A2 = 5'(a);
      step();
      chk("reclear_rd1_m", rd1_m, 32'h0);
      chk("reclear_rd2_a", rd2_a, 32'h0);
    end
    $display("read all 32 addresses after re-clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_bp.md
# reg_file_bp

Parametrised, registered-read, two-read/one-write register file for the CPU core, successor to the fixed 32x32 core register file. It adds write enable, read enable (output hold), optional hardwired-zero register 0, optional write-to-read bypass, and a post-reset clear sequencer. The sequencer zeroes every entry one per cycle and flags `READY` when done. It sits between decode (read addresses) and writeback (write port) in the core pipeline.

## Interface
Parameters:
- `XLEN`, 32: data width in bits.
- `NREG`, 32: number of registers, 2..1024; need not be a power of two.
- `AW`, `$clog2(NREG)`: address width, derived; do not override.
- `ZERO_REG`, 1: 1 = register 0 reads as 0 and ignores writes.
- `BYPASS`, 1: 1 = same-cycle write data forwarded to a matching read; 0 = read returns the old value.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `res`, input, 1: reset, synchronous, active-high.
- `A1`, input, AW: read address, port 1.
- `A2`, input, AW: read address, port 2.
- `RE`, input, 1: read enable; 0 holds `RD1`/`RD2`.
- `A3`, input, AW: write address.
- `WD`, input, XLEN: write data.
- `WE`, input, 1: write enable.
- `RD1`, output, XLEN: registered read data, port 1.
- `RD2`, output, XLEN: registered read data, port 2.
- `READY`, output, 1: 1 = clear sequence complete; reads and writes are accepted.

## Operation
- FSM has two states, INIT and RUN. Internal clear index `clr_idx` is AW bits wide.
- `res`=1 at a clock edge: state=INIT, `clr_idx`=0, `RD1`=`RD2`=0, `READY`=0. Array contents are not touched on that edge.
- INIT, `res`=0: write 0 to `REG[clr_idx]`, then increment `clr_idx`.
  - When `clr_idx`==NREG-1, the same edge also sets state=RUN and `READY`=1.
  - `WE`, `RE`, `A*` and `WD` are ignored; `RD1`/`RD2` stay 0.
- RUN, write: if `WE`=1 and `A3`<NREG and not (ZERO_REG and `A3`==0), then `REG[A3]` <= `WD`. Otherwise there is no write.
- RUN, read, evaluated per port (shown for port 1; port 2 is identical with `A2`/`RD2`):
  - `RE`=0: `RD1` holds its value.
  - `A1`>=NREG, or (ZERO_REG and `A1`==0): `RD1` <= 0.
  - BYPASS and the write is qualified per the rule above and `A3`==`A1`: `RD1` <= `WD`.
  - Otherwise: `RD1` <= `REG[A1]`, the pre-edge value.
- Both read ports may address the same register; both then return identical data.
- State stays RUN until `res`. A reset during INIT restarts the clear at index 0. A reset during RUN re-enters INIT and re-clears the whole array.

## Timing
- Read latency is 1 cycle: address presented before edge N gives data on the outputs after edge N.
- Write takes effect at the edge. A read of the same address at the next edge sees the new value regardless of BYPASS.
- Bypass is a same-edge collision only. With BYPASS=0 the collision returns the old contents.
- Clear latency: `READY` rises after exactly NREG rising edges with `res`=0, following the last `res`=1 edge.
- First accepted write or read is on the edge after `READY` is seen high.
- Reset values: `RD1`=0, `RD2`=0, `READY`=0. FSM state INIT, `clr_idx`=0.
- No combinational path from any input to any output.

## Test plan
- Reset/clear, NREG=32: hold `res` 3 cycles, then release -> `READY`=0 for 32 edges and 1 after the 32nd. Reading all 32 addresses then returns 0. Pulse `res` at clear edge 10 -> `READY` rises 32 edges after the new release.
- Write/read, RUN: write 0xDEADBEEF to reg 5, then read `A1`=5, `A2`=5 -> both outputs show 0xDEADBEEF one cycle later. With `WE`=0 and `A3`=6, a read of 6 stays 0.
- Zero register: write 0x1234 to reg 0 -> read returns 0 with ZERO_REG=1. With ZERO_REG=0, the read returns 0x1234.
- Bypass collision: reg 7 holds 0x11. Same edge: `WE`=1, `A3`=7, `WD`=0x22, `A1`=7 -> `RD1`=0x22 with BYPASS=1 and 0x11 with BYPASS=0. The next read of 7 returns 0x22 in both builds.
- Read hold and out-of-range: `RD1`=0xAA, then `RE`=0 while `A1` changes -> `RD1` stays 0xAA. With NREG=24, a write to address 30 is dropped and a read of 30 returns 0.
- Reset mid-RUN: fill regs 1..31 with nonzero data, assert `res` -> `RD1`/`RD2`=0 immediately and `READY`=0. After the clear completes, every register reads 0.
